// File: rtl/key_load_ctrl.sv
// Key load controller: assembles 16 serial bytes into a 128-bit key, hands it
// to the round-key generator with a level request, and waits for its done
// (ignoring stale done for MIN_HOLD cycles) or times out into a sticky error.
module key_load_ctrl #(
  parameter int unsigned MIN_HOLD = 11,
  parameter int unsigned TIMEOUT  = 64
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic [7:0]   byte_in,
  input  logic         byte_valid,
  output logic         byte_ready,
  input  logic         key_start,
  input  logic         change_key_done,
  output logic [127:0] rx_key,
  output logic         chg_key,
  output logic         key_loaded,
  output logic         key_err,
  output logic [4:0]   byte_cnt
);

  localparam int unsigned HoldW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    StCollect,
    StLoad,
    StErr
  } state_e;

  state_e           state_q, state_d;
  logic [127:0]     asm_q, asm_d;
  logic [127:0]     rx_key_q, rx_key_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic             loaded_q, loaded_d;

  logic             accept;
  logic             last_byte;
  logic             done_ok;
  logic             timeout_hit;
  logic [127:0]     asm_shift;

  // key_start wins over a simultaneous byte, so the byte is never consumed.
  assign accept      = byte_valid & byte_ready & ~key_start;
  assign last_byte   = (cnt_q == 5'd15);
  assign done_ok     = change_key_done & (hold_q >= HoldW'(MIN_HOLD));
  // Counter becomes TIMEOUT on this edge: the LOAD has lasted TIMEOUT cycles.
  assign timeout_hit = (hold_q >= HoldW'(TIMEOUT - 1));
  assign asm_shift   = (asm_q << 8) | {120'd0, byte_in};

  // State register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= StCollect;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; done has precedence over timeout.
  always_comb begin
    state_d = state_q;
    if (key_start) begin
      state_d = StCollect;
    end else begin
      unique case (state_q)
        StCollect: if (accept && last_byte) state_d = StLoad;
        StLoad: begin
          if (done_ok) begin
            state_d = StCollect;
          end else if (timeout_hit) begin
            state_d = StErr;
          end
        end
        StErr:     state_d = StErr;
        default:   state_d = StCollect;
      endcase
    end
  end

  // Outputs decoded directly from the state.
  always_comb begin
    byte_ready = 1'b0;
    chg_key    = 1'b0;
    key_err    = 1'b0;
    unique case (state_q)
      StCollect: byte_ready = 1'b1;
      StLoad:    chg_key    = 1'b1;
      StErr:     key_err    = 1'b1;
      default:   byte_ready = 1'b0;
    endcase
  end

  // Datapath next-state: byte assembly, key capture, hold counter, done pulse.
  always_comb begin
    asm_d    = asm_q;
    rx_key_d = rx_key_q;
    cnt_d    = cnt_q;
    hold_d   = hold_q;
    loaded_d = 1'b0;
    if (key_start) begin
      asm_d  = '0;
      cnt_d  = '0;
      hold_d = '0;
    end else begin
      loaded_d = (state_q == StLoad) & done_ok;
      if (accept) begin
        if (last_byte) begin
          rx_key_d = asm_shift;
          asm_d    = '0;
          cnt_d    = '0;
        end else begin
          asm_d = asm_shift;
          cnt_d = cnt_q + 5'd1;
        end
      end
      unique case (state_q)
        StLoad: begin
          if (hold_q < HoldW'(TIMEOUT)) hold_d = hold_q + HoldW'(1);
        end
        StCollect: hold_d = '0;
        default:   hold_d = hold_q;
      endcase
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      asm_q    <= '0;
      rx_key_q <= '0;
      cnt_q    <= '0;
      hold_q   <= '0;
      loaded_q <= 1'b0;
    end else begin
      asm_q    <= asm_d;
      rx_key_q <= rx_key_d;
      cnt_q    <= cnt_d;
      hold_q   <= hold_d;
      loaded_q <= loaded_d;
    end
  end

  assign rx_key     = rx_key_q;
  assign byte_cnt   = cnt_q;
  assign key_loaded = loaded_q;

endmodule

// File: tb/tb_key_load_ctrl.sv
// Directed bench for key_load_ctrl: a vector table for the byte collection
// path plus hand-written multi-cycle sequences for hold, timeout, abort,
// backpressure and reset.
module tb_key_load_ctrl;

  localparam int MinHold = 11;
  localparam int Timeout = 64;

  logic         clk;
  logic         n_rst;
  logic [7:0]   byte_in;
  logic         byte_valid;
  logic         byte_ready;
  logic         key_start;
  logic         change_key_done;
  logic [127:0] rx_key;
  logic         chg_key;
  logic         key_loaded;
  logic         key_err;
  logic [4:0]   byte_cnt;

  int checks = 0;
  int passes = 0;

  key_load_ctrl #(
    .MIN_HOLD(MinHold),
    .TIMEOUT (Timeout)
  ) dut (
    .clk            (clk),
    .n_rst          (n_rst),
    .byte_in        (byte_in),
    .byte_valid     (byte_valid),
    .byte_ready     (byte_ready),
    .key_start      (key_start),
    .change_key_done(change_key_done),
    .rx_key         (rx_key),
    .chg_key        (chg_key),
    .key_loaded     (key_loaded),
    .key_err        (key_err),
    .byte_cnt       (byte_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       valid;
    logic [7:0] data;
    logic       exp_ready;
    logic       exp_chg;
    logic       exp_loaded;
    logic [4:0] exp_cnt;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Sends 16 bytes base..base+15 back to back, leaving the DUT in LOAD cycle 0.
  task automatic load_key(input logic [7:0] base);
    for (int i = 0; i < 16; i++) begin
      byte_valid = 1'b1;
      byte_in    = base + 8'(i);
      cyc();
    end
    byte_valid = 1'b0;
  endtask

  function automatic logic [127:0] key_of(input logic [7:0] base);
    logic [127:0] k;
    for (int i = 0; i < 16; i++) k = {k[119:0], base + 8'(i)};
    return k;
  endfunction

  int n;
  int pulses;

  initial begin
    n_rst = 1'b0; byte_in = '0; byte_valid = 1'b0; key_start = 1'b0; change_key_done = 1'b0;
    for (int i = 0; i < 16; i++) begin
      vecs[i].valid      = 1'b1;
      vecs[i].data       = 8'(i);
      vecs[i].exp_ready  = (i != 15);
      vecs[i].exp_chg    = (i == 15);
      vecs[i].exp_loaded = 1'b0;
      vecs[i].exp_cnt    = 5'((i + 1) % 16);
    end

    // Reset state.
    #3;
    check("rst_ready", 128'(byte_ready), 128'd1);
    check("rst_chg", 128'(chg_key), 128'd0);
    check("rst_loaded", 128'(key_loaded), 128'd0);
    check("rst_err", 128'(key_err), 128'd0);
    check("rst_cnt", 128'(byte_cnt), 128'd0);
    check("rst_key", rx_key, 128'd0);
    #20 n_rst = 1'b1;
    cyc();

    // Normal collection from the table.
    for (int i = 0; i < 16; i++) begin
      byte_valid = vecs[i].valid;
      byte_in    = vecs[i].data;
      cyc();
      check($sformatf("vec%0d_cnt", i), 128'(byte_cnt), 128'(vecs[i].exp_cnt));
      check($sformatf("vec%0d_ready", i), 128'(byte_ready), 128'(vecs[i].exp_ready));
      check($sformatf("vec%0d_chg", i), 128'(chg_key), 128'(vecs[i].exp_chg));
      check($sformatf("vec%0d_loaded", i), 128'(key_loaded), 128'(vecs[i].exp_loaded));
    end
    byte_valid = 1'b0;
    check("normal_key", rx_key, 128'h000102030405060708090A0B0C0D0E0F);

    // Done at LOAD cycle 11.
    for (int i = 0; i < MinHold; i++) cyc();
    check("normal_chg_before_done", 128'(chg_key), 128'd1);
    change_key_done = 1'b1;
    cyc();
    change_key_done = 1'b0;
    check("normal_chg_after", 128'(chg_key), 128'd0);
    check("normal_loaded_pulse", 128'(key_loaded), 128'd1);
    cyc();
    check("normal_loaded_end", 128'(key_loaded), 128'd0);

    // Stale done held from before LOAD.
    change_key_done = 1'b1;
    load_key(8'h10);
    n = 0;
    while (chg_key && n < 200) begin n++; cyc(); end
    check("stale_chg_cycles", 128'(n), 128'(MinHold + 1));
    check("stale_loaded", 128'(key_loaded), 128'd1);
    change_key_done = 1'b0;
    cyc();
    check("stale_loaded_end", 128'(key_loaded), 128'd0);
    check("stale_key", rx_key, key_of(8'h10));

    // Timeout.
    load_key(8'h20);
    n = 0;
    while (chg_key && n < 200) begin n++; cyc(); end
    check("to_chg_cycles", 128'(n), 128'(Timeout));
    check("to_err", 128'(key_err), 128'd1);
    check("to_ready", 128'(byte_ready), 128'd0);
    byte_valid = 1'b1; byte_in = 8'h55;
    for (int i = 0; i < 3; i++) cyc();
    check("to_err_sticky", 128'(key_err), 128'd1);
    check("to_no_accept", 128'(byte_cnt), 128'd0);
    check("to_ready_held", 128'(byte_ready), 128'd0);
    byte_valid = 1'b0; key_start = 1'b1;
    cyc();
    key_start = 1'b0;
    check("to_clear_err", 128'(key_err), 128'd0);
    check("to_clear_cnt", 128'(byte_cnt), 128'd0);
    check("to_ready_back", 128'(byte_ready), 128'd1);
    check("to_key_kept", rx_key, key_of(8'h20));

    // Abort on the 9th byte.
    for (int i = 0; i < 8; i++) begin
      byte_valid = 1'b1; byte_in = 8'hA0 + 8'(i); cyc();
    end
    check("abort_cnt8", 128'(byte_cnt), 128'd8);
    byte_in = 8'hA8; key_start = 1'b1;
    cyc();
    key_start = 1'b0; byte_valid = 1'b0;
    check("abort_cnt", 128'(byte_cnt), 128'd0);
    check("abort_key_kept", rx_key, key_of(8'h20));
    load_key(8'h30);
    check("abort_next_key", rx_key, key_of(8'h30));
    // key_start beats an acceptable done in LOAD.
    for (int i = 0; i < MinHold; i++) cyc();
    change_key_done = 1'b1; key_start = 1'b1;
    cyc();
    change_key_done = 1'b0; key_start = 1'b0;
    check("abort_load_chg", 128'(chg_key), 128'd0);
    check("abort_load_noloaded", 128'(key_loaded), 128'd0);
    check("abort_load_ready", 128'(byte_ready), 128'd1);

    // Backpressure: byte held through LOAD.
    load_key(8'h40);
    byte_valid = 1'b1; byte_in = 8'hEE;
    for (int i = 0; i < MinHold; i++) cyc();
    check("bp_cnt_load", 128'(byte_cnt), 128'd0);
    check("bp_ready_load", 128'(byte_ready), 128'd0);
    change_key_done = 1'b1;
    cyc();
    change_key_done = 1'b0;
    check("bp_cnt_exit", 128'(byte_cnt), 128'd0);
    check("bp_key_kept", rx_key, key_of(8'h40));
    cyc();
    check("bp_accept", 128'(byte_cnt), 128'd1);
    for (int i = 1; i < 16; i++) begin
      byte_in = 8'(i); cyc();
    end
    byte_valid = 1'b0;
    check("bp_key", rx_key, 128'hEE0102030405060708090A0B0C0D0E0F);
    check("bp_chg", 128'(chg_key), 128'd1);

    // Reset mid-LOAD at LOAD cycle 5.
    for (int i = 0; i < 5; i++) cyc();
    change_key_done = 1'b1;
    #2 n_rst = 1'b0;
    #1;
    check("rl_chg", 128'(chg_key), 128'd0);
    check("rl_ready", 128'(byte_ready), 128'd1);
    check("rl_key", rx_key, 128'd0);
    check("rl_cnt", 128'(byte_cnt), 128'd0);
    check("rl_err", 128'(key_err), 128'd0);
    check("rl_loaded", 128'(key_loaded), 128'd0);
    #14 n_rst = 1'b1;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (key_loaded) pulses++;
    end
    change_key_done = 1'b0;
    check("rl_no_loaded", 128'(pulses), 128'd0);
    check("rl_ready_after", 128'(byte_ready), 128'd1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
